// File: rtl/vga_scanout_ctrl.sv
// vga_scanout_ctrl: VGA timing generator and pixel scanout.
// Free-running h/v position counters driven by en_i. The pixel handshake is
// combinational (px_ready_o); colour, sync, de, sof and underflow are
// registered one cycle behind the position that produced them.
// Optional build macro VGA_SCANOUT_TESTPATTERN_EN adds test_en_i, which
// replaces source pixels with 8 vertical colour bars.
module vga_scanout_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   input  logic        px_valid_i,
   input  logic [23:0] px_data_i,
`ifdef VGA_SCANOUT_TESTPATTERN_EN
   input  logic        test_en_i,
`endif
   output logic        px_ready_o,
   output logic [7:0]  r_o,
   output logic [7:0]  g_o,
   output logic [7:0]  b_o,
   output logic        hs_o,
   output logic        vs_o,
   output logic        de_o,
   output logic        sof_o,
   output logic        underflow_o
);

   localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
   localparam logic [11:0] H_SS_C   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE_C   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST_C = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
   localparam logic [11:0] V_SS_C   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE_C   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST_C = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic        HS_LVL   = (HS_POL != 0);
   localparam logic        VS_LVL   = (VS_POL != 0);

   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic [23:0] pix_q, pix_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic        sof_q, sof_d;
   logic        uf_q, uf_d;

   logic        active;
   logic        in_hs;
   logic        in_vs;
   logic        at_origin;
   logic        test_mode;
   logic [23:0] bar_rgb;

   assign active    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
   assign in_hs     = (h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C);
   assign in_vs     = (v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C);
   assign at_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

`ifdef VGA_SCANOUT_TESTPATTERN_EN
   logic [14:0] bar_idx;
   assign test_mode = test_en_i;
   assign bar_idx   = {h_cnt_q, 3'b000} / 15'(H_ACTIVE);
   assign bar_rgb   = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
`else
   assign test_mode = 1'b0;
   assign bar_rgb   = 24'h000000;
`endif

   // Source is only asked for a pixel when it will actually be displayed.
   assign px_ready_o = en_i && active && !test_mode;

   // Position counters: held at the origin while disabled so scanout always
   // restarts at pixel (0,0).
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (!en_i) begin
         h_cnt_d = 12'd0;
         v_cnt_d = 12'd0;
      end else if (h_cnt_q == H_LAST_C) begin
         h_cnt_d = 12'd0;
         v_cnt_d = (v_cnt_q == V_LAST_C) ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
         h_cnt_d = h_cnt_q + 12'd1;
      end
   end

   // Output stage: blanked/inactive by default; underflow is sticky and is
   // only re-evaluated from scratch on the start-of-frame pixel.
   always_comb begin
      pix_d = 24'h000000;
      de_d  = 1'b0;
      sof_d = 1'b0;
      hs_d  = ~HS_LVL;
      vs_d  = ~VS_LVL;
      uf_d  = uf_q;
      if (en_i) begin
         hs_d  = in_hs ? HS_LVL : ~HS_LVL;
         vs_d  = in_vs ? VS_LVL : ~VS_LVL;
         sof_d = at_origin;
         if (at_origin) begin
            uf_d = 1'b0;
         end
         if (active) begin
            de_d = 1'b1;
            if (test_mode) begin
               pix_d = bar_rgb;
            end else if (px_valid_i) begin
               pix_d = px_data_i;
            end else begin
               uf_d = 1'b1;
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt_q <= 12'd0;
         v_cnt_q <= 12'd0;
         pix_q   <= 24'h000000;
         hs_q    <= ~HS_LVL;
         vs_q    <= ~VS_LVL;
         de_q    <= 1'b0;
         sof_q   <= 1'b0;
         uf_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         pix_q   <= pix_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         sof_q   <= sof_d;
         uf_q    <= uf_d;
      end
   end

   assign r_o         = pix_q[23:16];
   assign g_o         = pix_q[15:8];
   assign b_o         = pix_q[7:0];
   assign hs_o        = hs_q;
   assign vs_o        = vs_q;
   assign de_o        = de_q;
   assign sof_o       = sof_q;
   assign underflow_o = uf_q;

endmodule
